// File: rtl/brfu_pkg.sv
// Shared types for the branch functional unit: condition classes, default flag bit
// positions and the default-width result-queue entry.
package brfu_pkg;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    POS    = 2'd1,
    MINVAL = 2'd2,
    NEG    = 2'd3
  } cond_class_e;

  localparam int BRFU_DATA_W    = 8;
  localparam int BRFU_ROBID_W   = 4;
  localparam int BRFU_FLAGS_W   = 8;
  localparam int BRFU_TAKEN_BIT = 5;
  localparam int BRFU_MISP_BIT  = 6;
  localparam int BRFU_QDEPTH    = 2;

  typedef struct packed {
    logic [BRFU_ROBID_W-1:0] robid;
    logic [7:0]              wbs;
    logic [BRFU_FLAGS_W-1:0] flags;
    logic [BRFU_DATA_W-1:0]  value;
  } brfu_entry_t;

endpackage

// File: rtl/branch_fu_q_if.sv
// Issue, flush and CDB/ROB drain signals of branch_fu_q. The slave modport is the unit,
// the master modport is whoever issues and grants.
interface branch_fu_q_if #(
  parameter int DATA_W  = 8,
  parameter int ROBID_W = 4,
  parameter int FLAGS_W = 8
);
  logic                          input_transmit;
  logic [7:0]                    operand;
  logic [1:0][DATA_W-1:0]        depvals;
  logic [7:0]                    wbs;
  logic [FLAGS_W-1:0]            flags;
  logic [ROBID_W-1:0]            robid;
  logic                          flush;
  logic                          cdb_transmit;
  logic                          cdb_transmit_out;
  logic [ROBID_W-1:0]            cdb_id;
  logic [DATA_W-1:0]             cdb_val;
  logic                          rob_transmit;
  logic                          rob_transmit_out;
  logic [ROBID_W-1:0]            robid_out;
  logic [FLAGS_W-1:0]            flags_out;
  logic [7:0]                    wbs_out;
  logic [DATA_W-1:0]             value_out;
  logic                          busy;

  modport slave (
    input  input_transmit, operand, depvals, wbs, flags, robid, flush,
           cdb_transmit, rob_transmit,
    output cdb_transmit_out, cdb_id, cdb_val, rob_transmit_out, robid_out,
           flags_out, wbs_out, value_out, busy
  );

  modport master (
    output input_transmit, operand, depvals, wbs, flags, robid, flush,
           cdb_transmit, rob_transmit,
    input  cdb_transmit_out, cdb_id, cdb_val, rob_transmit_out, robid_out,
           flags_out, wbs_out, value_out, busy
  );
endinterface

// File: rtl/brfu_resolve.sv
// Combinational branch resolution: classify the tested value, pick the taken bit from the
// condition mask and fold it into the flags. BRFU_PREDICT_EN adds the mispredict flag.
module brfu_resolve
  import brfu_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FLAGS_W   = 8,
  parameter int TAKEN_BIT = 5,
  parameter int MISP_BIT  = 6
) (
  input  logic [DATA_W-1:0]  a,
  input  logic [3:0]         cond_mask,
  input  logic               pred,
  input  logic [FLAGS_W-1:0] flags_in,
  output logic [FLAGS_W-1:0] flags_upd
);

  cond_class_e cls;
  logic        taken;

  always_comb begin
    cls       = cond_class_e'({a[DATA_W-1], |a[DATA_W-2:0]});
    taken     = cond_mask[cls];
    flags_upd = flags_in;
    flags_upd[TAKEN_BIT] = taken;
`ifdef BRFU_PREDICT_EN
    flags_upd[MISP_BIT] = taken ^ pred;
`else
    flags_upd[MISP_BIT] = flags_in[MISP_BIT];
`endif
  end

`ifndef BRFU_PREDICT_EN
  logic unused_pred;
  assign unused_pred = pred;
`endif

endmodule

// File: rtl/branch_fu_q.sv
// Branch functional unit with a QDEPTH-entry result FIFO drained independently on the CDB
// and ROB channels. Optional prediction check under BRFU_PREDICT_EN.
module branch_fu_q
  import brfu_pkg::*;
#(
  parameter int DATA_W    = BRFU_DATA_W,
  parameter int ROBID_W   = BRFU_ROBID_W,
  parameter int FLAGS_W   = BRFU_FLAGS_W,
  parameter int TAKEN_BIT = BRFU_TAKEN_BIT,
  parameter int MISP_BIT  = BRFU_MISP_BIT,
  parameter int QDEPTH    = BRFU_QDEPTH
) (
  input logic          clk,
  input logic          rst,
  branch_fu_q_if.slave bus
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ROBID_W-1:0] robid;
    logic [7:0]         wbs;
    logic [FLAGS_W-1:0] flags;
    logic [DATA_W-1:0]  value;
  } entry_t;

  entry_t             mem [QDEPTH];
  entry_t             new_entry;
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;
  logic               cdb_done, rob_done;
  logic               head_valid, cdb_req, rob_req, cdb_fin, rob_fin;
  logic               push, pop, busy_i;
  logic [FLAGS_W-1:0] flags_upd;

  brfu_resolve #(
    .DATA_W    (DATA_W),
    .FLAGS_W   (FLAGS_W),
    .TAKEN_BIT (TAKEN_BIT),
    .MISP_BIT  (MISP_BIT)
  ) u_resolve (
    .a         (bus.depvals[0]),
    .cond_mask (bus.operand[7:4]),
    .pred      (bus.operand[3]),
    .flags_in  (bus.flags),
    .flags_upd (flags_upd)
  );

  logic unused_operand;
  assign unused_operand = ^bus.operand[2:0];

  always_comb begin
    new_entry.robid = bus.robid;
    new_entry.wbs   = bus.wbs;
    new_entry.flags = flags_upd;
    new_entry.value = bus.depvals[1];
  end

  // A channel counts as finished if it was done earlier or is granted now; the head pops
  // on the edge where both are finished, so the second grant completes the entry.
  always_comb begin
    busy_i     = (count == CNT_W'(QDEPTH));
    head_valid = (count != '0);
    cdb_req    = head_valid & ~cdb_done;
    rob_req    = head_valid & ~rob_done;
    cdb_fin    = cdb_done | (bus.cdb_transmit & cdb_req);
    rob_fin    = rob_done | (bus.rob_transmit & rob_req);
    pop        = head_valid & cdb_fin & rob_fin;
    push       = bus.input_transmit & ~busy_i & ~bus.flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      cdb_done <= 1'b0;
      rob_done <= 1'b0;
    end else if (bus.flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      cdb_done <= 1'b0;
      rob_done <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop) begin
        head     <= head + PTR_W'(1);
        cdb_done <= 1'b0;
        rob_done <= 1'b0;
      end else begin
        cdb_done <= cdb_fin;
        rob_done <= rob_fin;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[tail] <= new_entry;
    end
  end

  assign bus.busy             = busy_i;
  assign bus.cdb_transmit_out = cdb_req;
  assign bus.rob_transmit_out = rob_req;
  assign bus.cdb_id           = mem[head].robid;
  assign bus.cdb_val          = mem[head].value;
  assign bus.robid_out        = mem[head].robid;
  assign bus.flags_out        = mem[head].flags;
  assign bus.wbs_out          = mem[head].wbs;
  assign bus.value_out        = mem[head].value;

endmodule

// File: tb/tb_branch_fu_q.sv
// Scoreboard bench for branch_fu_q: directed scenarios, then randomized traffic against a
// queue-based reference model. Define BRFU_PREDICT_EN to cover the mispredict flag.
module tb_branch_fu_q;
  import brfu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_fu_q_if bus ();
  branch_fu_q dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending results plus per-channel done flags.
  brfu_entry_t exp_q[$];
  bit          m_cdb_done, m_rob_done;

  function automatic brfu_entry_t model_entry(input logic [7:0] a, input logic [7:0] b,
      input logic [7:0] operand, input logic [3:0] robid, input logic [7:0] wbs,
      input logic [7:0] flags);
    brfu_entry_t e;
    int          cls;
    bit          taken;
    if (a == 8'h00)      cls = 0;
    else if (a < 8'h80)  cls = 1;
    else if (a == 8'h80) cls = 2;
    else                 cls = 3;
    taken   = operand[4 + cls];
    e.robid = robid;
    e.wbs   = wbs;
    e.value = b;
    e.flags = flags;
    e.flags[BRFU_TAKEN_BIT] = taken;
`ifdef BRFU_PREDICT_EN
    e.flags[BRFU_MISP_BIT] = taken ^ operand[3];
`endif
    return e;
  endfunction

  always @(posedge clk or negedge rst) begin
    int  sz;
    bit  cg, rg, cd, rd, do_pop, do_push;
    if (!rst) begin
      exp_q.delete();
      m_cdb_done = 0;
      m_rob_done = 0;
    end else if (bus.flush) begin
      exp_q.delete();
      m_cdb_done = 0;
      m_rob_done = 0;
    end else begin
      sz      = exp_q.size();
      cg      = bus.cdb_transmit && sz > 0 && !m_cdb_done;
      rg      = bus.rob_transmit && sz > 0 && !m_rob_done;
      cd      = m_cdb_done || cg;
      rd      = m_rob_done || rg;
      do_pop  = sz > 0 && cd && rd;
      do_push = bus.input_transmit && sz < BRFU_QDEPTH;
      if (do_pop) begin
        void'(exp_q.pop_front());
        m_cdb_done = 0;
        m_rob_done = 0;
      end else begin
        m_cdb_done = cd;
        m_rob_done = rd;
      end
      if (do_push)
        exp_q.push_back(model_entry(bus.depvals[0], bus.depvals[1], bus.operand, bus.robid,
                                    bus.wbs, bus.flags));
    end
  end

  // Monitor: compares whatever the DUT presents against the model head on every negedge.
  always @(negedge clk) begin
    bit exp_cdb, exp_rob;
    exp_cdb = exp_q.size() > 0 && !m_cdb_done;
    exp_rob = exp_q.size() > 0 && !m_rob_done;
    check("busy", bus.busy, exp_q.size() == BRFU_QDEPTH);
    check("cdb_req", bus.cdb_transmit_out, exp_cdb);
    check("rob_req", bus.rob_transmit_out, exp_rob);
    if (bus.cdb_transmit_out && exp_q.size() > 0) begin
      check("cdb_id", bus.cdb_id, exp_q[0].robid);
      check("cdb_val", bus.cdb_val, exp_q[0].value);
    end
    if (bus.rob_transmit_out && exp_q.size() > 0) begin
      check("robid_out", bus.robid_out, exp_q[0].robid);
      check("flags_out", bus.flags_out, exp_q[0].flags);
      check("wbs_out", bus.wbs_out, exp_q[0].wbs);
      check("value_out", bus.value_out, exp_q[0].value);
    end
  end

  task automatic idle();
    bus.input_transmit = 0;
    bus.operand        = '0;
    bus.depvals[0]     = '0;
    bus.depvals[1]     = '0;
    bus.wbs            = '0;
    bus.flags          = '0;
    bus.robid          = '0;
    bus.flush          = 0;
    bus.cdb_transmit   = 0;
    bus.rob_transmit   = 0;
  endtask

  task automatic set_issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cond,
      input logic pred, input logic [3:0] robid);
    bus.input_transmit = 1;
    bus.depvals[0]     = a;
    bus.depvals[1]     = b;
    bus.operand        = {cond, pred, 3'b000};
    bus.robid          = robid;
    bus.wbs            = 8'hA0 | 8'(robid);
    bus.flags          = 8'h00;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_cdb_req"}, bus.cdb_transmit_out, 0);
    check({tag, "_rob_req"}, bus.rob_transmit_out, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_cdb_id"}, bus.cdb_id, 0);
    check({tag, "_cdb_val"}, bus.cdb_val, 0);
    check({tag, "_flags"}, bus.flags_out, 0);
    check({tag, "_wbs"}, bus.wbs_out, 0);
  endtask

  task automatic drain_one();
    bus.input_transmit = 0;
    bus.cdb_transmit   = 1;
    bus.rob_transmit   = 1;
    step();
    idle();
  endtask

  task automatic taken_case(input logic [7:0] a, input logic [3:0] cond, input logic exp_t,
      input string name);
    set_issue(a, 8'h11, cond, 1'b0, 4'h2);
    step();
    idle();
    check(name, bus.flags_out[BRFU_TAKEN_BIT], exp_t);
    drain_one();
  endtask

  initial begin
    idle();
    repeat (2) step();
    check_zero_outputs("reset");
    rst = 1;

    // 1: single issue visible on both channels next cycle
    set_issue(8'h00, 8'h40, 4'h1, 1'b0, 4'd3);
    step();
    idle();
    check("t1_cdb_id", bus.cdb_id, 3);
    check("t1_cdb_val", bus.cdb_val, 8'h40);
    check("t1_taken", bus.flags_out[BRFU_TAKEN_BIT], 1);
    check("t1_reqs", {bus.cdb_transmit_out, bus.rob_transmit_out}, 2'b11);
    drain_one();
    check("t1_empty", {bus.cdb_transmit_out, bus.rob_transmit_out}, 2'b00);

    // 2: condition classes
    taken_case(8'h05, 4'h1, 1'b0, "t2_pos");
    taken_case(8'h80, 4'h4, 1'b1, "t2_minval");
    taken_case(8'hF0, 4'h8, 1'b1, "t2_neg");
    taken_case(8'h00, 4'hE, 1'b0, "t2_zero_clr");

    // 3: fill, drop third, staggered grants
    set_issue(8'h01, 8'h21, 4'h2, 1'b0, 4'd1);
    step();
    set_issue(8'h01, 8'h22, 4'h2, 1'b0, 4'd2);
    step();
    check("t3_busy", bus.busy, 1);
    set_issue(8'h01, 8'h29, 4'h2, 1'b0, 4'd9);
    step();
    idle();
    bus.cdb_transmit = 1;
    step();
    bus.cdb_transmit = 0;
    check("t3_cdb_done", {bus.cdb_transmit_out, bus.rob_transmit_out}, 2'b01);
    step();
    check("t3_busy_hold", bus.busy, 1);
    bus.rob_transmit = 1;
    step();
    bus.rob_transmit = 0;
    check("t3_busy_clr", bus.busy, 0);
    check("t3_next_head", bus.cdb_id, 2);
    drain_one();
    check("t3_third_dropped", bus.cdb_transmit_out, 0);

    // 4: full, both grants plus issue in the same cycle
    set_issue(8'h00, 8'h31, 4'h1, 1'b0, 4'd4);
    step();
    set_issue(8'h00, 8'h32, 4'h1, 1'b0, 4'd5);
    step();
    set_issue(8'h00, 8'h3F, 4'h1, 1'b0, 4'd7);
    bus.cdb_transmit = 1;
    bus.rob_transmit = 1;
    step();
    idle();
    check("t4_busy", bus.busy, 0);
    check("t4_head", bus.cdb_id, 5);
    drain_one();
    check("t4_count1", bus.cdb_transmit_out, 0);

    // 5: flush beats a simultaneous issue
    set_issue(8'h00, 8'h41, 4'h1, 1'b0, 4'd6);
    step();
    set_issue(8'h00, 8'h42, 4'h1, 1'b0, 4'd8);
    step();
    set_issue(8'h00, 8'h43, 4'h1, 1'b0, 4'd10);
    bus.flush = 1;
    step();
    idle();
    check("t5_reqs", {bus.cdb_transmit_out, bus.rob_transmit_out}, 2'b00);
    check("t5_busy", bus.busy, 0);
    set_issue(8'h00, 8'h44, 4'h1, 1'b0, 4'd11);
    step();
    idle();
    check("t5_after_flush", bus.cdb_id, 11);
    drain_one();

`ifdef BRFU_PREDICT_EN
    // 6: mispredict flag
    set_issue(8'h00, 8'h51, 4'h1, 1'b0, 4'd12);
    step();
    idle();
    check("t6_misp", bus.flags_out[BRFU_MISP_BIT], 1);
    drain_one();
    set_issue(8'h00, 8'h52, 4'h1, 1'b1, 4'd13);
    step();
    idle();
    check("t6_pred_ok", bus.flags_out[BRFU_MISP_BIT], 0);
    drain_one();
`endif

    // Randomized traffic; the monitor checks every cycle against the model.
    for (int i = 0; i < 600; i++) begin
      bus.input_transmit = ($urandom_range(0, 9) < 6);
      bus.operand        = 8'($urandom);
      bus.depvals[0]     = 8'($urandom_range(0, 3) == 0 ? 8'h80 :
                              ($urandom_range(0, 3) == 0 ? 0 : $urandom));
      bus.depvals[1]     = 8'($urandom);
      bus.wbs            = 8'($urandom);
      bus.flags          = 8'($urandom);
      bus.robid          = 4'($urandom);
      bus.flush          = ($urandom_range(0, 39) == 0);
      bus.cdb_transmit   = $urandom_range(0, 1);
      bus.rob_transmit   = $urandom_range(0, 1);
      if (i == 300) begin
        #2 rst = 0;
        #1 check_zero_outputs("async_rst");
        step();
        rst = 1;
      end else begin
        step();
      end
    end

    idle();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
